// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared constants, types and helpers for the serial pattern
//             detector family.
//  Contents : default pattern length / counter width, bit-order convention,
//             fill-counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int LEN_DEFAULT   = 4;
    localparam int CNT_W_DEFAULT = 8;

    // Patterns are written MSB-first: bit LEN-1 is the first bit on the wire,
    // bit 0 is the most recently received bit.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } pat_order_e;

    localparam pat_order_e PAT_ORDER = ORDER_MSB_FIRST;

    // Width of the fill counter, which must hold 0..LEN-1.
    function automatic int fill_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param_if
//  Purpose  : Serial-stream / pattern-load / status bundle of the pattern
//             detector.
//  Signals  : in_valid, in_bit, pat_load, pat_in, overlap (to detector)
//             pat_mask_in (to detector, only with SEQDET_MASK_EN)
//             out, match_cnt, cnt_sat (from detector)
//  Modports : master - stream source / status consumer
//             slave  - detector
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             pat_load;
    logic [LEN-1:0]   pat_in;
    logic             overlap;
`ifdef SEQDET_MASK_EN
    logic [LEN-1:0]   pat_mask_in;
`endif
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
`ifdef SEQDET_MASK_EN
        output pat_mask_in,
`endif
        output in_valid, in_bit, pat_load, pat_in, overlap,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
`ifdef SEQDET_MASK_EN
        input  pat_mask_in,
`endif
        input  in_valid, in_bit, pat_load, pat_in, overlap,
        output out, match_cnt, cnt_sat
    );

endinterface
`default_nettype wire

// File: rtl/seq_det_match_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_match_cnt
//  Purpose  : Saturating event counter; holds at all-ones, never wraps.
//  Ports    : clk   - clock
//             rst   - synchronous active-high reset (clears the count)
//             inc_i - count one event this cycle
//             cnt_o - current count
//             sat_o - count is all-ones (derived from registered state)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_match_cnt #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    output logic      [CNT_W-1:0] cnt_o,
    output logic                  sat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Parametrised Mealy serial-pattern detector with runtime-loadable
//             pattern, per-cycle overlap selection and saturating match count.
//  Ports    : clk   - clock
//             reset - synchronous active-high reset
//             bus   - seq_detector_param_if.slave (stream in, pattern load,
//                     overlap select, match flag, match count, saturation)
//  Options  : SEQDET_MASK_EN - adds pat_mask_in and a don't-care mask register
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN             = LEN_DEFAULT,
    parameter logic [LEN-1:0] PATTERN_DEFAULT = LEN'(4'b1011),
    parameter int             CNT_W           = CNT_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    seq_detector_param_if.slave   bus
);

    localparam int             FW       = fill_w(LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);

    logic [LEN-1:0] pattern_q, pattern_d;
    logic [LEN-2:0] hist_q,    hist_d;
    logic [FW-1:0]  fill_q,    fill_d;

    logic [LEN-1:0] w_window;
    logic [LEN-2:0] w_hist_shift;
    logic           w_hit;
    logic           w_accept;
    logic           w_out;
    logic           w_sat;

    // Candidate window: stored history followed by the bit on the wire now.
    assign w_window = {hist_q, bus.in_bit};

`ifdef SEQDET_MASK_EN
    logic [LEN-1:0] mask_q, mask_d;
    assign w_hit = (((w_window ^ pattern_q) & ~mask_q) == '0);
`else
    assign w_hit = (w_window == pattern_q);
`endif

    generate
        if (LEN == 2) begin : g_hist_len2
            assign w_hist_shift = bus.in_bit;
        end else begin : g_hist_wide
            assign w_hist_shift = {hist_q[LEN-3:0], bus.in_bit};
        end
    endgenerate

    // A pattern load in the same cycle swallows the incoming bit.
    assign w_accept = bus.in_valid & ~bus.pat_load;
    assign w_out    = w_accept & ~reset & (fill_q == FILL_MAX) & w_hit;

    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
`ifdef SEQDET_MASK_EN
        mask_d    = mask_q;
`endif
        if (bus.pat_load) begin
            pattern_d = bus.pat_in;
            fill_d    = '0;
`ifdef SEQDET_MASK_EN
            mask_d    = bus.pat_mask_in;
`endif
        end else if (bus.in_valid) begin
            if (w_out && !bus.overlap) begin
                // Non-overlapping: start collecting a fresh pattern.
                fill_d = '0;
            end else begin
                hist_d = w_hist_shift;
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= PATTERN_DEFAULT;
            hist_q    <= '0;
            fill_q    <= '0;
`ifdef SEQDET_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
`ifdef SEQDET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (w_out),
        .cnt_o (bus.match_cnt),
        .sat_o (w_sat)
    );

    assign bus.out     = w_out;
    // The counter still shows its old value during a reset cycle; the
    // saturation flag is forced low there.
    assign bus.cnt_sat = w_sat & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Self-checking bench for seq_detector_param (LEN=4). Two
//             instances share all stimulus: one with CNT_W=8, one with CNT_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int LEN = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_detector_param_if #(.LEN(LEN), .CNT_W(8)) if0 ();
    seq_detector_param_if #(.LEN(LEN), .CNT_W(2)) if1 ();

    seq_detector_param #(.LEN(LEN), .PATTERN_DEFAULT(4'b1011), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    seq_detector_param #(.LEN(LEN), .PATTERN_DEFAULT(4'b1011), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model for the CNT_W=8 instance: every bit accepted since the
    // last clear, kept in arrival order.
    bit       mq[$];
    bit [3:0] m_pat;
    bit [3:0] m_mask;
    int       m_cnt;

    task automatic model_reset();
        mq.delete();
        m_pat  = 4'b1011;
        m_mask = 4'b0000;
        m_cnt  = 0;
    endtask

    function automatic bit model_hit(bit v, bit b, bit pl);
        bit [3:0] w;
        int n;
        n = mq.size();
        if (!v || pl || n < LEN - 1) return 1'b0;
        w[0] = b;
        for (int k = 1; k < LEN; k++) w[k] = mq[n - k];
        return ((w ^ m_pat) & ~m_mask) == 4'b0000;
    endfunction

    task automatic model_step(bit rs, bit v, bit b, bit pl, bit [3:0] pi, bit [3:0] mk, bit ov);
        bit hit;
        hit = model_hit(v, b, pl);
        if (rs) begin
            model_reset();
        end else if (pl) begin
            m_pat = pi;
`ifdef SEQDET_MASK_EN
            m_mask = mk;
`else
            m_mask = 4'b0000 & mk;
`endif
            mq.delete();
        end else if (v) begin
            if (hit && m_cnt < 255) m_cnt++;
            if (hit && !ov) mq.delete();
            else mq.push_back(b);
        end
    endtask

    // Applies one cycle of stimulus to both instances, then settles 1 unit.
    task automatic drive(bit rs, bit v, bit b, bit pl, bit [3:0] pi, bit [3:0] mk, bit ov);
        @(negedge clk);
        reset        = rs;
        if0.in_valid = v;   if1.in_valid = v;
        if0.in_bit   = b;   if1.in_bit   = b;
        if0.pat_load = pl;  if1.pat_load = pl;
        if0.pat_in   = pi;  if1.pat_in   = pi;
        if0.overlap  = ov;  if1.overlap  = ov;
`ifdef SEQDET_MASK_EN
        if0.pat_mask_in = mk;
        if1.pat_mask_in = mk;
`else
        if (mk != mk) reset = 1'bx;
`endif
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        if0.in_valid = 1'b1;  if1.in_valid = 1'b1;
        if0.in_bit   = 1'b1;  if1.in_bit   = 1'b1;
        if0.pat_load = 1'b0;  if1.pat_load = 1'b0;
        if0.pat_in   = 4'h0;  if1.pat_in   = 4'h0;
        if0.overlap  = 1'b1;  if1.overlap  = 1'b1;
`ifdef SEQDET_MASK_EN
        if0.pat_mask_in = 4'h0;
        if1.pat_mask_in = 4'h0;
`endif
        #7;
        n_tests++;
        if (if0.out !== 1'b0 || if0.cnt_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle: out=%b cnt_sat=%b, required 0/0", if0.out, if0.cnt_sat);
        end
        #8;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        model_reset();
        n_tests++;
        if (if0.out !== 1'b0 || if0.match_cnt !== 8'd0 || if0.cnt_sat !== 1'b0 ||
            if1.match_cnt !== 2'd0 || if1.cnt_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%b cnt=%0d sat=%b cnt2=%0d sat2=%b, required 0/0/0/0/0",
                     if0.out, if0.match_cnt, if0.cnt_sat, if1.match_cnt, if1.cnt_sat);
        end
    endtask

    task automatic test_stream(bit ov);
        logic [15:0] stream;
        bit          exp;
        stream = 16'b0010110110010110;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, stream[15-i], 1'b0, 4'h0, 4'h0, ov);
            exp = (i == 5) || (i == 14) || (ov && i == 8);
            n_tests++;
            if (if0.out !== exp) begin
                n_fail++;
                $display("FAIL stream_ov%0d bit %0d: out=%b, required %b", ov, i, if0.out, exp);
            end
            model_step(1'b0, 1'b1, stream[15-i], 1'b0, 4'h0, 4'h0, ov);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, ov);
        n_tests++;
        if (if0.match_cnt !== (ov ? 8'd3 : 8'd2)) begin
            n_fail++;
            $display("FAIL stream_ov%0d count: match_cnt=%0d, required %0d", ov, if0.match_cnt, ov ? 3 : 2);
        end
    endtask

    task automatic test_overlap();
        test_stream(1'b1);
    endtask

    task automatic test_nonoverlap();
        test_stream(1'b0);
    endtask

    // Runs straight after the non-overlap stream, so match_cnt starts at 2.
    task automatic test_pat_load();
        logic [7:0] s;
        bit         exp;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 4'h0, 1'b1);
        n_tests++;
        if (if0.out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle: out=%b, required 0", if0.out);
        end
        model_step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 4'h0, 1'b1);
        s = 8'b0110_1011;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, s[7-i], 1'b0, 4'h0, 4'h0, 1'b1);
            exp = (i == 3);
            n_tests++;
            if (if0.out !== exp) begin
                n_fail++;
                $display("FAIL new_pattern bit %0d: out=%b, required %b", i, if0.out, exp);
            end
            model_step(1'b0, 1'b1, s[7-i], 1'b0, 4'h0, 4'h0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        n_tests++;
        if (if0.match_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL load_count: match_cnt=%0d, required 3", if0.match_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] s;
        bit          exp;
        int          k;
        s = 16'b1011011011011011;
        k = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, s[15-i], 1'b0, 4'h0, 4'h0, 1'b1);
            exp = (i >= 3) && (i % 3 == 0);
            n_tests++;
            if (if1.out !== exp || if1.match_cnt !== 2'((k > 3) ? 3 : k) || if1.cnt_sat !== (k >= 3)) begin
                n_fail++;
                $display("FAIL sat bit %0d: out=%b cnt=%0d sat=%b, required %b/%0d/%b",
                         i, if1.out, if1.match_cnt, if1.cnt_sat, exp, (k > 3) ? 3 : k, k >= 3);
            end
            if (exp) k++;
            model_step(1'b0, 1'b1, s[15-i], 1'b0, 4'h0, 4'h0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        n_tests++;
        if (if1.match_cnt !== 2'd3 || if1.cnt_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d sat=%b, required 3/1", if1.match_cnt, if1.cnt_sat);
        end
    endtask

`ifdef SEQDET_MASK_EN
    task automatic test_mask();
        logic [11:0] s;
        bit          exp;
        s = 12'b1111_1001_0001;
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b0110, 1'b0);
        model_step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b0110, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, s[11-i], 1'b0, 4'h0, 4'h0, 1'b0);
            exp = (i == 3) || (i == 7);
            n_tests++;
            if (if0.out !== exp) begin
                n_fail++;
                $display("FAIL mask bit %0d: out=%b, required %b", i, if0.out, exp);
            end
            model_step(1'b0, 1'b1, s[11-i], 1'b0, 4'h0, 4'h0, 1'b0);
        end
    endtask
`endif

    task automatic test_random();
        bit       rs, v, b, pl, ov, exp;
        bit [3:0] pi, mk;
        int       fails_before;
        do_reset();
        fails_before = n_fail;
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            pl = ($urandom_range(0, 29) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            ov = 1'($urandom);
            pi = 4'($urandom);
            mk = 4'($urandom) & 4'($urandom);
            drive(rs, v, b, pl, pi, mk, ov);
            exp = !rs && model_hit(v, b, pl);
            n_tests++;
            if (if0.out !== exp || if0.match_cnt !== 8'(m_cnt) || if0.cnt_sat !== (!rs && m_cnt == 255)) begin
                n_fail++;
                if (n_fail - fails_before <= 10)
                    $display("FAIL random cycle %0d: out=%b cnt=%0d sat=%b, required %b/%0d/%b",
                             i, if0.out, if0.match_cnt, if0.cnt_sat, exp, m_cnt, !rs && m_cnt == 255);
            end
            model_step(rs, v, b, pl, pi, mk, ov);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_pat_load();
        test_saturation();
`ifdef SEQDET_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
